// File: rtl/vga_timing_sequencer.sv
// vga_timing_sequencer: programmable VGA raster timing with shadowed config applied at frame end; define VGA_SYNC_POL_EN for programmable sync polarity at address 8
module vga_timing_sequencer #(
   parameter int H_ACT_DEF = 640,
   parameter int H_SS_DEF  = 656,
   parameter int H_SE_DEF  = 752,
   parameter int H_TOT_DEF = 800,
   parameter int V_ACT_DEF = 480,
   parameter int V_SS_DEF  = 490,
   parameter int V_SE_DEF  = 492,
   parameter int V_TOT_DEF = 525
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        pix_ce,
   input  logic        cfg_valid,
   output logic        cfg_ready,
   input  logic [3:0]  cfg_addr,
   input  logic [10:0] cfg_data,
   input  logic        cfg_commit,
   output logic        cfg_pending,
   output logic        cfg_err,
   output logic        hsync,
   output logic        vsync,
   output logic        de,
   output logic [10:0] x,
   output logic [9:0]  y,
   output logic        line_start,
   output logic        frame_start
);
   typedef enum logic [1:0] {RUN, ARMED, APPLY} state_t;
   state_t state, state_n;
   logic [10:0] hcnt, h_act, h_ss, h_se, h_tot, s_h_act, s_h_ss, s_h_se, s_h_tot;
   logic [10:0] w_h_act, w_h_ss, w_h_se, w_h_tot;
   logic [9:0]  vcnt, v_act, v_ss, v_se, v_tot, s_v_act, s_v_ss, s_v_se, s_v_tot;
   logic [9:0]  w_v_act, w_v_ss, w_v_se, w_v_tot;
   logic [1:0]  pol;
   logic        wr, ok, h_end, v_end, f_end;
   // a write in the same clk as a commit is visible to the check through w_*
   assign wr      = cfg_valid && cfg_ready;
   assign w_h_act = (wr && cfg_addr == 4'd0) ? cfg_data : s_h_act;
   assign w_h_ss  = (wr && cfg_addr == 4'd1) ? cfg_data : s_h_ss;
   assign w_h_se  = (wr && cfg_addr == 4'd2) ? cfg_data : s_h_se;
   assign w_h_tot = (wr && cfg_addr == 4'd3) ? cfg_data : s_h_tot;
   assign w_v_act = (wr && cfg_addr == 4'd4) ? cfg_data[9:0] : s_v_act;
   assign w_v_ss  = (wr && cfg_addr == 4'd5) ? cfg_data[9:0] : s_v_ss;
   assign w_v_se  = (wr && cfg_addr == 4'd6) ? cfg_data[9:0] : s_v_se;
   assign w_v_tot = (wr && cfg_addr == 4'd7) ? cfg_data[9:0] : s_v_tot;
   assign ok = (w_h_act < w_h_ss) && (w_h_ss < w_h_se) && (w_h_se <= w_h_tot) && (w_h_tot >= 11'd2) &&
               (w_v_act < w_v_ss) && (w_v_ss < w_v_se) && (w_v_se <= w_v_tot) && (w_v_tot >= 10'd2);
   assign h_end = hcnt == h_tot - 11'd1;
   assign v_end = vcnt == v_tot - 10'd1;
   assign f_end = pix_ce && h_end && v_end;
`ifdef VGA_SYNC_POL_EN
   logic [1:0] s_pol, w_pol;
   assign w_pol = (wr && cfg_addr == 4'd8) ? cfg_data[1:0] : s_pol;
   // polarity shadow and live copy, applied together with the timing set
   always_ff @(posedge clk)
      if (!rst_n) begin
         s_pol <= 2'b00;
         pol   <= 2'b00;
      end else begin
         s_pol <= w_pol;
         if (state == APPLY) pol <= s_pol;
      end
`else
   assign pol = 2'b00;
`endif
   // shadow set follows accepted writes
   always_ff @(posedge clk)
      if (!rst_n) begin
         s_h_act <= 11'(H_ACT_DEF);
         s_h_ss  <= 11'(H_SS_DEF);
         s_h_se  <= 11'(H_SE_DEF);
         s_h_tot <= 11'(H_TOT_DEF);
         s_v_act <= 10'(V_ACT_DEF);
         s_v_ss  <= 10'(V_SS_DEF);
         s_v_se  <= 10'(V_SE_DEF);
         s_v_tot <= 10'(V_TOT_DEF);
      end else begin
         s_h_act <= w_h_act;
         s_h_ss  <= w_h_ss;
         s_h_se  <= w_h_se;
         s_h_tot <= w_h_tot;
         s_v_act <= w_v_act;
         s_v_ss  <= w_v_ss;
         s_v_se  <= w_v_se;
         s_v_tot <= w_v_tot;
      end
   // live thresholds change only in APPLY, right after the frame wrap
   always_ff @(posedge clk)
      if (!rst_n) begin
         h_act <= 11'(H_ACT_DEF);
         h_ss  <= 11'(H_SS_DEF);
         h_se  <= 11'(H_SE_DEF);
         h_tot <= 11'(H_TOT_DEF);
         v_act <= 10'(V_ACT_DEF);
         v_ss  <= 10'(V_SS_DEF);
         v_se  <= 10'(V_SE_DEF);
         v_tot <= 10'(V_TOT_DEF);
      end else if (state == APPLY) begin
         h_act <= s_h_act;
         h_ss  <= s_h_ss;
         h_se  <= s_h_se;
         h_tot <= s_h_tot;
         v_act <= s_v_act;
         v_ss  <= s_v_ss;
         v_se  <= s_v_se;
         v_tot <= s_v_tot;
      end
   // raster counters advance on pixel enable
   always_ff @(posedge clk)
      if (!rst_n) begin
         hcnt <= '0;
         vcnt <= '0;
      end else if (pix_ce) begin
         hcnt <= h_end ? '0 : hcnt + 11'd1;
         if (h_end) vcnt <= v_end ? '0 : vcnt + 10'd1;
      end
   // registered raster outputs, one clk behind the counters
   always_ff @(posedge clk)
      if (!rst_n) begin
         de          <= 1'b0;
         hsync       <= 1'b1;
         vsync       <= 1'b1;
         x           <= '0;
         y           <= '0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         line_start  <= pix_ce && hcnt == '0;
         frame_start <= pix_ce && hcnt == '0 && vcnt == '0;
         if (pix_ce) begin
            de    <= (hcnt < h_act) && (vcnt < v_act);
            hsync <= (hcnt >= h_ss && hcnt < h_se) ? pol[0] : ~pol[0];
            vsync <= (vcnt >= v_ss && vcnt < v_se) ? pol[1] : ~pol[1];
            x     <= hcnt;
            y     <= vcnt;
         end
      end
   // rejected commit pulses for one clk
   always_ff @(posedge clk)
      if (!rst_n) cfg_err <= 1'b0;
      else cfg_err <= state == RUN && cfg_commit && !ok;
   // config FSM state register
   always_ff @(posedge clk)
      if (!rst_n) state <= RUN;
      else state <= state_n;
   // config FSM next state
   always_comb begin
      state_n = (state == RUN) ? ((cfg_commit && ok) ? ARMED : RUN) :
                (state == ARMED) ? (f_end ? APPLY : ARMED) : RUN;
   end
   // config FSM outputs
   always_comb begin
      cfg_ready   = state == RUN;
      cfg_pending = state != RUN;
   end
endmodule

// File: tb/tb_vga_timing_sequencer.sv
// tb_vga_timing_sequencer: scoreboard bench for vga_timing_sequencer on a scaled-down raster
module tb_vga_timing_sequencer;
   localparam int HA = 8, HS = 10, HE = 12, HT = 16, VA = 4, VS = 5, VE = 6, VT = 8;
   logic clk = 0, rst_n = 0, pix_ce = 0, cfg_valid = 0, cfg_commit = 0;
   logic [3:0] cfg_addr = '0;
   logic [10:0] cfg_data = '0;
   logic cfg_ready, cfg_pending, cfg_err, hsync, vsync, de, line_start, frame_start;
   logic [10:0] x;
   logic [9:0] y;
   vga_timing_sequencer #(.H_ACT_DEF(HA), .H_SS_DEF(HS), .H_SE_DEF(HE), .H_TOT_DEF(HT),
                          .V_ACT_DEF(VA), .V_SS_DEF(VS), .V_SE_DEF(VE), .V_TOT_DEF(VT)) dut (
      .clk(clk), .rst_n(rst_n), .pix_ce(pix_ce), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_commit(cfg_commit), .cfg_pending(cfg_pending),
      .cfg_err(cfg_err), .hsync(hsync), .vsync(vsync), .de(de), .x(x), .y(y),
      .line_start(line_start), .frame_start(frame_start));
   always #5 clk = ~clk;
   int checks = 0, failures = 0;
   logic [28:0] q[$];
   int L[9], S[9];
   int mh, mv, st;
   logic [10:0] ox;
   logic [9:0] oy;
   logic ode, ohs, ovs, ols, ofs, oerr;
   function automatic bit shadow_ok();
      return S[0] < S[1] && S[1] < S[2] && S[2] <= S[3] && S[3] >= 2 &&
             S[4] < S[5] && S[5] < S[6] && S[6] <= S[7] && S[7] >= 2;
   endfunction
   task automatic model_reset();
      L = '{HA, HS, HE, HT, VA, VS, VE, VT, 0};
      S = L;
      mh = 0; mv = 0; st = 0;
      ox = '0; oy = '0; ode = 0; ohs = 1; ovs = 1; ols = 0; ofs = 0; oerr = 0;
   endtask
   task automatic step(input bit ce);
      logic [28:0] e, got;
      bit fend;
      pix_ce = ce;
      if (!rst_n) model_reset();
      else begin
         fend = ce && mh == L[3] - 1 && mv == L[7] - 1;
         if (cfg_valid && st == 0) begin
            if (cfg_addr <= 3) S[cfg_addr] = int'(cfg_data);
            else if (cfg_addr <= 7) S[cfg_addr] = int'(cfg_data[9:0]);
`ifdef VGA_SYNC_POL_EN
            else if (cfg_addr == 8) S[8] = int'(cfg_data[1:0]);
`endif
         end
         oerr = 0;
         ols = ce && mh == 0;
         ofs = ce && mh == 0 && mv == 0;
         if (ce) begin
            ox = mh[10:0];
            oy = mv[9:0];
            ode = mh < L[0] && mv < L[4];
            ohs = (mh >= L[1] && mh < L[2]) ? L[8][0] : ~L[8][0];
            ovs = (mv >= L[5] && mv < L[6]) ? L[8][1] : ~L[8][1];
            if (mh == L[3] - 1) begin
               mh = 0;
               mv = (mv == L[7] - 1) ? 0 : mv + 1;
            end else mh++;
         end
         if (st == 0) begin
            if (cfg_commit) begin
               if (shadow_ok()) st = 1;
               else oerr = 1;
            end
         end else if (st == 1) begin
            if (fend) st = 2;
         end else begin
            L = S;
            st = 0;
         end
      end
      e = {ox, oy, ode, ohs, ovs, ols, ofs, st == 0, st != 0, oerr};
      q.push_back(e);
      @(posedge clk);
      #1;
      e = q.pop_front();
      got = {x, y, de, hsync, vsync, line_start, frame_start, cfg_ready, cfg_pending, cfg_err};
      checks++;
      if (got !== e) begin
         failures++;
         $display("FAIL scoreboard t=%0t got=%h exp=%h (x,y,de,hs,vs,ls,fs,rdy,pend,err)", $time, got, e);
      end
   endtask
   task automatic cfg_step(input logic [3:0] a, input logic [10:0] d, input bit v, input bit c);
      cfg_addr = a; cfg_data = d; cfg_valid = v; cfg_commit = c;
      step(1);
      cfg_valid = 0; cfg_commit = 0;
   endtask
   task automatic count_frame(input int n, input int exp_de, input int exp_hs, input int exp_vs);
      int w, dc, hc, vc;
      w = 0;
      while (w < 400 && frame_start !== 1'b1) begin step(1); w++; end
      checks++;
      if (frame_start !== 1'b1) begin
         failures++;
         $display("FAIL frame_start_timeout got=%b exp=1", frame_start);
         return;
      end
      dc = 0; hc = 0; vc = 0;
      for (int i = 0; i < n; i++) begin
         if (i > 0) step(1);
         dc += int'(de); hc += int'(!hsync); vc += int'(!vsync);
      end
      checks++;
      if (dc != exp_de) begin failures++; $display("FAIL de_count got=%0d exp=%0d", dc, exp_de); end
      checks++;
      if (hc != exp_hs) begin failures++; $display("FAIL hsync_low_count got=%0d exp=%0d", hc, exp_hs); end
      checks++;
      if (vc != exp_vs) begin failures++; $display("FAIL vsync_low_count got=%0d exp=%0d", vc, exp_vs); end
   endtask
   task automatic measure_line(input bit tog, input int exp);
      int w, c;
      bit ph;
      w = 0; ph = 0;
      while (w < 2000 && line_start !== 1'b1) begin step(tog ? ph : 1'b1); ph = ~ph; w++; end
      c = 0;
      do begin step(tog ? ph : 1'b1); ph = ~ph; c++; end while (c < 2000 && line_start !== 1'b1);
      checks++;
      if (c != exp) begin failures++; $display("FAIL line_period got=%0d exp=%0d", c, exp); end
   endtask
   task automatic wait_apply();
      int w;
      w = 0;
      while (w < 400 && cfg_pending !== 1'b0) begin step(1); w++; end
      checks++;
      if (cfg_pending !== 1'b0) begin failures++; $display("FAIL apply_timeout got=%b exp=0", cfg_pending); end
   endtask
   task automatic test_reset();
      rst_n = 0;
      step(1); step(1);
      checks++;
      if ({x, y, de, hsync, vsync, line_start, frame_start} !== {21'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0}) begin
         failures++; $display("FAIL reset_outputs got=%h", {x, y, de, hsync, vsync, line_start, frame_start});
      end
      checks++;
      if ({cfg_ready, cfg_pending, cfg_err} !== 3'b100) begin
         failures++; $display("FAIL reset_cfg got=%b exp=100", {cfg_ready, cfg_pending, cfg_err});
      end
      rst_n = 1;
   endtask
   task automatic test_defaults();
      count_frame(HT * VT, HA * VA, (HE - HS) * VT, (VE - VS) * HT);
      measure_line(0, HT);
   endtask
   task automatic test_ce_toggle();
      for (int i = 0; i < 100; i++) step(i[0]);
      measure_line(1, 2 * HT);
   endtask
   task automatic test_bad_commit();
      cfg_step(4'd1, 11'd14, 1, 0);
      cfg_step(4'd2, 11'd11, 1, 0);
      cfg_step(4'd0, 11'd0, 0, 1);
      checks++;
      if ({cfg_err, cfg_pending} !== 2'b10) begin
         failures++; $display("FAIL bad_commit got=%b exp=10", {cfg_err, cfg_pending});
      end
      step(1);
      checks++;
      if (cfg_err !== 1'b0) begin failures++; $display("FAIL err_single_pulse got=%b exp=0", cfg_err); end
      count_frame(HT * VT, HA * VA, (HE - HS) * VT, (VE - VS) * HT);
   endtask
   task automatic test_write_commit_same();
      cfg_step(4'd2, 11'd12, 1, 0);
      cfg_step(4'd1, 11'd10, 1, 1);
      checks++;
      if ({cfg_pending, cfg_err} !== 2'b10) begin
         failures++; $display("FAIL write_commit_same got=%b exp=10", {cfg_pending, cfg_err});
      end
      wait_apply();
   endtask
   task automatic test_reconfig();
      repeat (30) step(1);
      cfg_step(4'd0, 11'd4, 1, 0);
      cfg_step(4'd1, 11'd5, 1, 0);
      cfg_step(4'd2, 11'd6, 1, 0);
      cfg_step(4'd3, 11'd8, 1, 0);
      cfg_step(4'd0, 11'd0, 0, 1);
      checks++;
      if ({cfg_pending, cfg_ready} !== 2'b10) begin
         failures++; $display("FAIL armed_handshake got=%b exp=10", {cfg_pending, cfg_ready});
      end
      cfg_step(4'd3, 11'd3, 1, 0);
      wait_apply();
      measure_line(0, 8);
      count_frame(8 * VT, 4 * VA, 1 * VT, (VE - VS) * 8);
   endtask
   task automatic test_reset_armed();
      cfg_step(4'd3, 11'd20, 1, 1);
      repeat (5) step(1);
      rst_n = 0;
      step(1);
      checks++;
      if ({cfg_pending, cfg_ready, hsync, vsync, x, y} !== {1'b0, 1'b1, 1'b1, 1'b1, 21'd0}) begin
         failures++; $display("FAIL reset_armed got=%h", {cfg_pending, cfg_ready, hsync, vsync, x, y});
      end
      rst_n = 1;
      count_frame(HT * VT, HA * VA, (HE - HS) * VT, (VE - VS) * HT);
   endtask
   task automatic test_polarity();
      int ehs, evs;
`ifdef VGA_SYNC_POL_EN
      ehs = HT * VT - (HE - HS) * VT; evs = HT * VT - (VE - VS) * HT;
`else
      ehs = (HE - HS) * VT; evs = (VE - VS) * HT;
`endif
      cfg_step(4'd8, 11'd3, 1, 1);
      wait_apply();
      count_frame(HT * VT, HA * VA, ehs, evs);
   endtask
   initial begin
      model_reset();
      test_reset();
      test_defaults();
      test_ce_toggle();
      test_bad_commit();
      test_write_commit_same();
      test_reconfig();
      test_reset_armed();
      test_polarity();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
